// File: rtl/game_pkg.sv
// Shared types and constants for the per-player game-state logic.
package game_pkg;

    typedef logic [3:0] bcd_t;

    typedef enum logic [1:0] {
        IDLE,
        ADD,
        SAT,
        COMMIT
    } stat_state_t;

    localparam bcd_t BCD_MAX    = 4'd9;
    localparam int   NUM_DIGITS = 4;

    // Award nibbles above 9 are treated as 9.
    function automatic bcd_t clamp_bcd(input logic [3:0] n);
        return (n > BCD_MAX) ? BCD_MAX : n;
    endfunction

endpackage

// File: rtl/bcd_digit_add.sv
// Single BCD digit adder with carry in/out; a digit sum is at most 9+9+1.
module bcd_digit_add
    import game_pkg::*;
(
    input  bcd_t a,
    input  bcd_t b,
    input  logic cin,
    output bcd_t sum,
    output logic cout
);

    logic [4:0] raw;

    always_comb begin
        raw = 5'(a) + 5'(b) + 5'(cin);
        if (raw > 5'(BCD_MAX)) begin
            sum  = 4'(raw - 5'd10);
            cout = 1'b1;
        end else begin
            sum  = raw[3:0];
            cout = 1'b0;
        end
    end

endmodule

// File: rtl/player_stats.sv
// Per-player score (4 BCD digits, saturating at 9999) and damage/invulnerability keeper.
module player_stats
    import game_pkg::*;
#(
    parameter int MAX_DMG     = 8,
    parameter int IFRAMES     = 60,
    parameter int FRAME_CNT_W = 7
) (
    input  logic       Clk,
    input  logic       Reset,
    input  logic       frame_clk,
    input  logic       new_game,
    input  logic       add_valid,
    output logic       add_ready,
    input  logic [7:0] add_pts,
    input  logic       hit,
    output logic [3:0] score0,
    output logic [3:0] score1,
    output logic [3:0] score2,
    output logic [3:0] score3,
    output logic [3:0] hp,
    output logic       dead,
    output logic       invuln
);

    stat_state_t state_q, state_d;

    bcd_t       score_q [NUM_DIGITS];
    bcd_t       work_q  [NUM_DIGITS];
    bcd_t       op_ones_q, op_tens_q;
    logic       carry_q;
    logic [2:0] idx_q;

    logic [3:0]             hp_q;
    logic [FRAME_CNT_W-1:0] timer_q;
    logic                   frame_cur_q, frame_prev_q;
    logic                   frame_rise;

    logic accept, do_digit, do_sat, do_commit;
    bcd_t op_b, dig_sum;
    logic dig_cout;

    assign dead       = (hp_q == 4'(MAX_DMG));
    assign invuln     = (timer_q != '0);
    assign hp         = hp_q;
    assign frame_rise = frame_cur_q & ~frame_prev_q;

    assign score0 = score_q[0];
    assign score1 = score_q[1];
    assign score2 = score_q[2];
    assign score3 = score_q[3];

    always_comb begin
        // NOTE: every output of this block gets a default first, so no path leaves one unassigned and no latch is inferred.
        state_d   = state_q;
        add_ready = 1'b0;
        accept    = 1'b0;
        do_digit  = 1'b0;
        do_sat    = 1'b0;
        do_commit = 1'b0;
        case (state_q)
            IDLE: begin
                add_ready = !dead;
                if (add_valid && !dead) begin
                    accept  = 1'b1;
                    state_d = ADD;
                end
            end
            // The carry out of the thousands digit is judged from the registered carry, one cycle after the last digit.
            ADD: begin
                if (idx_q != 3'(NUM_DIGITS)) begin
                    do_digit = 1'b1;
                end else begin
                    state_d = carry_q ? SAT : COMMIT;
                end
            end
            SAT: begin
                do_sat  = 1'b1;
                state_d = COMMIT;
            end
            COMMIT: begin
                do_commit = 1'b1;
                state_d   = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge Clk) begin
        // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
        if (!Reset || new_game) state_q <= IDLE;
        else                    state_q <= state_d;
    end

    always_comb begin
        case (idx_q[1:0])
            2'd0:    op_b = op_ones_q;
            2'd1:    op_b = op_tens_q;
            default: op_b = 4'd0;
        endcase
    end

    bcd_digit_add u_digit_add (
        .a    (work_q[idx_q[1:0]]),
        .b    (op_b),
        .cin  (carry_q),
        .sum  (dig_sum),
        .cout (dig_cout)
    );

    always_ff @(posedge Clk) begin
        // NOTE: the work digits are cleared with the score so an aborted add leaves nothing behind.
        if (!Reset || new_game) begin
            for (int i = 0; i < NUM_DIGITS; i++) begin
                score_q[i] <= '0;
                work_q[i]  <= '0;
            end
            op_ones_q <= '0;
            op_tens_q <= '0;
            carry_q   <= 1'b0;
            idx_q     <= '0;
        end else begin
            if (accept) begin
                op_ones_q <= clamp_bcd(add_pts[3:0]);
                op_tens_q <= clamp_bcd(add_pts[7:4]);
                work_q    <= score_q;
                carry_q   <= 1'b0;
                idx_q     <= '0;
            end
            if (do_digit) begin
                work_q[idx_q[1:0]] <= dig_sum;
                carry_q            <= dig_cout;
                idx_q              <= idx_q + 3'd1;
            end
            if (do_sat) begin
                for (int i = 0; i < NUM_DIGITS; i++) work_q[i] <= BCD_MAX;
            end
            if (do_commit) score_q <= work_q;
        end
    end

    // Damage and invulnerability run every cycle regardless of the score FSM.
    always_ff @(posedge Clk) begin
        if (!Reset || new_game) begin
            hp_q         <= '0;
            timer_q      <= '0;
            frame_cur_q  <= 1'b0;
            frame_prev_q <= 1'b0;
        end else begin
            frame_cur_q  <= frame_clk;
            frame_prev_q <= frame_cur_q;
            if (hit && !dead && !invuln) begin
                hp_q    <= hp_q + 4'd1;
                timer_q <= FRAME_CNT_W'(IFRAMES);
            end else if (frame_rise && invuln) begin
                timer_q <= timer_q - FRAME_CNT_W'(1);
            end
        end
    end

endmodule

// File: doc/player_stats.md
Name: player_stats

Overview:
- Per-player game-state keeper that produces the values the on-screen score and heart display consumes.
- Outputs four BCD score digits (score0 = ones … score3 = thousands) and a damage count hp, where 0 = all hearts full and MAX_DMG = dead.
- Accepts point-award transactions over a valid/ready handshake and hit pulses from collision logic.
- Instantiated once per player in the top level.

Parameters:
MAX_DMG, 8, damage count at which the player is dead (fits 4 bits)
IFRAMES, 60, invulnerability length after a hit, in frame_clk periods
FRAME_CNT_W, 7, width of invulnerability counter (must hold IFRAMES)

Ports:
Clk  input  1  system clock
Reset  input  1  synchronous, active-low reset
frame_clk  input  1  vertical-sync-rate frame clock, sampled in Clk domain
new_game  input  1  one-cycle pulse: clear all stats
add_valid  input  1  point award request
add_ready  output  1  block can accept award this cycle
add_pts  input  8  award in BCD: [7:4] tens, [3:0] ones
hit  input  1  one-cycle damage pulse
score0, score1, score2, score3  output  4 each  committed BCD score digits
hp  output  4  damage taken, 0..MAX_DMG
dead  output  1  hp == MAX_DMG
invuln  output  1  invulnerability timer nonzero

Behaviour:
- Reset (Reset==0 at Clk edge):
  - All score digits = 0, hp = 0, dead = 0, invuln = 0.
  - FSM = IDLE, add_ready = 1, frame edge register = 0.
- new_game:
  - Has the same effect as reset, one cycle later.
  - Overrides every other input in the same cycle.
  - Aborts any in-flight add; partial results are discarded.
- FSM states:
  - IDLE:
    - add_ready = !dead.
    - On add_valid && add_ready: capture add_pts, with any nibble >9 clamped to 9.
    - Copy committed digits into work registers, clear carry and digit index, go to ADD.
  - ADD:
    - One digit per cycle, index 0..3.
    - work[i] + operand[i] + carry; operand[2..3] = 0.
    - If sum > 9: subtract 10, carry = 1; otherwise carry = 0.
    - After index 3: go to SAT if carry = 1, otherwise COMMIT.
  - SAT: load all work digits with 9 (score saturates at 9999), go to COMMIT.
  - COMMIT: copy work digits to score outputs, go to IDLE.
  - add_ready = 0 in ADD, SAT and COMMIT.
- Latency:
  - Handshake at edge T.
  - New score visible on outputs after edge T+6 (T+7 with saturation).
  - Outputs never show partially added digits.
- Once started, an add completes even if dead asserts mid-operation.
- Hit, evaluated every cycle independent of FSM state:
  - If hit && !dead && !invuln: hp increments by 1 and the invulnerability timer loads IFRAMES.
  - Otherwise the hit is ignored.
  - hp never exceeds MAX_DMG.
- Invulnerability timer:
  - frame_clk is registered; a rising edge is detected as cur & ~prev.
  - Timer decrements by 1 per detected rising edge while nonzero.
  - invuln = (timer != 0).
  - A hit in the same cycle as a frame edge loads IFRAMES; the decrement is dropped.
- dead:
  - Combinational from registered hp (hp == MAX_DMG).
  - Sticky until reset or new_game.
- Width rule: digit sum is at most 9+9+1 = 19; compute in 5 bits.

Decomposition:
- Shared package game_pkg holds:
  - FSM enum stat_state_t {IDLE, ADD, SAT, COMMIT}.
  - Constants BCD_MAX = 4'd9 and NUM_DIGITS = 4.
  - Typedef bcd_t = logic [3:0].
- One natural sub-module, bcd_digit_add:
  - Inputs: a, b, cin.
  - Outputs: sum, cout.
  - Combinational; used by the ADD state.
- Invulnerability timer and frame-edge detect remain inline.

Test Plan:
- Reset low one cycle, then high -> scores 0,0,0,0; hp=0; dead=0; invuln=0; add_ready=1.
- add_pts=8'h47 twice from score 0 -> score 0094 committed; outputs unchanged until the COMMIT edge (T+6).
- Score 9990, add 8'h25 -> carry out of thousands, SAT state, score 9999 at T+7; add_ready returns high afterwards.
- Hit at cycle 0 -> hp=1, invuln=1; second hit 5 cycles later ignored (hp stays 1); after 60 frame_clk rising edges invuln=0; next hit -> hp=2.
- Eight spaced hits -> hp=8, dead=1, add_ready=0; further hit pulses and add_valid are ignored.
- Issue add, then pulse new_game during ADD -> all outputs cleared next cycle and FSM in IDLE; the aborted add never commits.
